// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream demultiplexer: select encoding and pointer width.
package stream_demux_pkg;

  // Channel-select encoding carried on in_sel
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Pointer width for a FIFO of the given depth (depth is a power of two)
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  localparam int unsigned DEFAULT_DEPTH = 2;
  localparam int unsigned DEFAULT_PTR_W = ptr_width(DEFAULT_DEPTH);

endpackage

// File: rtl/demux_fifo.sv
// Per-channel FIFO: single push port, single pop port, registered full flag and occupancy.
module demux_fifo
  import stream_demux_pkg::*;
#(
  parameter int unsigned B     = 32,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PW   = ptr_width(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [B-1:0]  push_data,
  output logic          full,
  input  logic          pop,
  output logic          valid,
  output logic [B-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [B-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even when it is popped in the same cycle
  assign full      = (count_q == CW'(DEPTH));
  assign valid     = (count_q != '0);
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign do_push   = push & ~full;
  assign do_pop    = pop & valid;

  // Storage, pointers and occupancy; reset clears storage so head_data reads zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer: steers each input word into channel A or B FIFO.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned B     = 32,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sel,
  input  logic [B-1:0]             in_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [B-1:0]             a_data,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [B-1:0]             b_data,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);

  logic a_full;
  logic b_full;
  logic accept;

  // Ready depends only on registered full flags, never on a_ready/b_ready
  assign in_ready = (in_sel == SEL_B) ? ~b_full : ~a_full;
  assign accept   = in_valid & in_ready;

  demux_fifo #(
    .B     (B),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept & (in_sel == SEL_A)),
    .push_data (in_data),
    .full      (a_full),
    .pop       (a_ready),
    .valid     (a_valid),
    .head_data (a_data),
    .count     (a_count)
  );

  demux_fifo #(
    .B     (B),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (accept & (in_sel == SEL_B)),
    .push_data (in_data),
    .full      (b_full),
    .pop       (b_ready),
    .valid     (b_valid),
    .head_data (b_data),
    .count     (b_count)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: queue-based model checked every cycle plus directed literal checks.
module tb_stream_demux;

  localparam int unsigned B     = 32;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sel;
  logic [B-1:0]  in_data;
  logic          a_valid;
  logic          a_ready;
  logic [B-1:0]  a_data;
  logic          b_valid;
  logic          b_ready;
  logic [B-1:0]  b_data;
  logic [1:0]    a_count;
  logic [1:0]    b_count;

  int checks = 0;
  int errors = 0;

  logic [B-1:0] qa [$];
  logic [B-1:0] qb [$];
  logic [B-1:0] a_log [$];

  stream_demux #(
    .B     (B),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next falling edge; inputs are driven here
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Behavioural model: two bounded queues, refusal decided from occupancy before the edge
  initial begin
    bit pa, pb, acc;
    forever begin
      @(posedge clk or negedge reset_n);
      if (reset_n !== 1'b1) begin
        qa.delete();
        qb.delete();
      end else begin
        pa  = a_ready && (qa.size() > 0);
        pb  = b_ready && (qb.size() > 0);
        acc = in_valid && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        if (pa) a_log.push_back(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc) begin
          if (in_sel) qb.push_back(in_data);
          else        qa.push_back(in_data);
        end
      end
    end
  end

  // Compare DUT against the model every cycle on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      check("a_valid", a_valid, qa.size() != 0);
      check("b_valid", b_valid, qb.size() != 0);
      check("a_count", a_count, qa.size());
      check("b_count", b_count, qb.size());
      check("in_ready", in_ready, in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
      if (qa.size() > 0) check("a_data", a_data, qa[0]);
      if (qb.size() > 0) check("b_data", b_data, qb[0]);
      check("a_count_bound", a_count <= DEPTH, 1'b1);
    end
  end

  initial begin
    int k;
    int guard;
    bit acc;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    cyc();
    cyc();
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_a_data", a_data, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);
    reset_n = 1'b1;

    // Routing: A word then B word, both consumers ready
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h1111_1111;
    cyc();
    check("route_a_valid", a_valid, 1'b1);
    check("route_a_data", a_data, 32'h1111_1111);
    in_sel = 1'b1; in_data = 32'h2222_2222;
    cyc();
    check("route_a_once", a_valid, 1'b0);
    check("route_b_valid", b_valid, 1'b1);
    check("route_b_data", b_data, 32'h2222_2222);
    in_valid = 1'b0;
    cyc();
    check("route_b_once", b_valid, 1'b0);

    // Isolation: B stalled while A keeps flowing
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'hB0;
    cyc();
    in_data = 32'hB1;
    cyc();
    check("iso_b_count", b_count, 2);
    check("iso_b_ready", in_ready, 1'b0);
    in_sel = 1'b0; in_data = 32'hA0;
    #1;
    check("iso_a_ready", in_ready, 1'b1);
    cyc();
    check("iso_a_count", a_count, 1);
    check("iso_a_data", a_data, 32'hA0);
    in_valid = 1'b0; b_ready = 1'b1;
    check("iso_b_head0", b_data, 32'hB0);
    cyc();
    check("iso_b_head1", b_data, 32'hB1);
    cyc();
    check("iso_b_empty", b_valid, 1'b0);
    b_ready = 1'b0; a_ready = 1'b1;
    cyc();
    check("iso_a_drained", a_count, 0);

    // Full channel with simultaneous pop: push refused, accepted next cycle
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h100;
    cyc();
    in_data = 32'h101;
    cyc();
    check("full_a_count", a_count, 2);
    a_ready = 1'b1; in_data = 32'h102;
    #1;
    check("full_refuse", in_ready, 1'b0);
    cyc();
    check("full_pop_count", a_count, 1);
    check("full_head", a_data, 32'h101);
    a_ready = 1'b0;
    cyc();
    check("full_refill", a_count, 2);
    in_valid = 1'b0; a_ready = 1'b1;
    cyc();
    cyc();
    check("full_drained", a_count, 0);

    // Wrap-around: words 0..9 to A with a_ready toggling
    a_log.delete();
    in_valid = 1'b1; in_sel = 1'b0;
    k = 0; guard = 0;
    while (k < 10 && guard < 100) begin
      in_data = k;
      a_ready = guard[0];
      #1;
      acc = in_ready;
      cyc();
      if (acc) k++;
      guard++;
    end
    check("wrap_no_timeout", guard < 100, 1'b1);
    in_valid = 1'b0; a_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("wrap_log_size", a_log.size(), 10);
    for (int i = 0; i < 10 && i < a_log.size(); i++) check("wrap_order", a_log[i], i);

    // Asynchronous reset mid-run with both channels holding two words
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hAA00;
    cyc();
    in_data = 32'hAA01;
    cyc();
    in_sel = 1'b1; in_data = 32'hBB00;
    cyc();
    in_data = 32'hBB01;
    cyc();
    check("pre_rst_a_count", a_count, 2);
    check("pre_rst_b_count", b_count, 2);
    in_valid = 1'b0; in_sel = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_a_valid", a_valid, 1'b0);
    check("mid_rst_b_valid", b_valid, 1'b0);
    check("mid_rst_a_count", a_count, 0);
    check("mid_rst_b_count", b_count, 0);
    check("mid_rst_a_data", a_data, 32'h0);
    check("mid_rst_b_data", b_data, 32'h0);
    check("mid_rst_ready_a", in_ready, 1'b1);
    in_sel = 1'b1;
    #1;
    check("mid_rst_ready_b", in_ready, 1'b1);
    cyc();
    reset_n = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h5;
    cyc();
    check("post_rst_accept", a_count, 1);
    check("post_rst_data", a_data, 32'h5);
    in_valid = 1'b0; a_ready = 1'b1;
    cyc();

    // Random soak against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      a_ready  = 1'($urandom_range(0, 1));
      b_ready  = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It routes each input word to channel A or channel B, selected per word by `in_sel`. Each channel is buffered in its own small FIFO, so a stalled destination never blocks words already queued for the other. It sits wherever one producer (debug unit, pipeline stage, bus bridge) must feed two independent consumers, and it is the routing counterpart of the 2:1 word selector.

## Interface
- `B`, 32: word width in bits.
- `DEPTH`, 2: entries per channel FIFO; power of two, ≥ 2.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input word offered.
- `in_ready` output 1: input word accepted this cycle when `in_valid & in_ready`.
- `in_sel` input 1: destination of the offered word; 0 routes to A, 1 routes to B.
- `in_data` input B: offered word.
- `a_valid` output 1: channel A head word available.
- `a_ready` input 1: channel A consumer takes the head word when `a_valid & a_ready`.
- `a_data` output B: channel A head word.
- `b_valid`, `b_ready`, `b_data`: same as the A ports, for channel B.
- `a_count`, `b_count` output $clog2(DEPTH)+1: occupancy of each channel FIFO.

## Operation
- Accept: `in_ready = in_sel ? ~b_full : ~a_full`. The full flags are registered state, so there is no combinational path from `a_ready`/`b_ready` to `in_ready`.
- On accept, `in_data` is written at the selected channel's write pointer. That pointer and its count increment.
- Pop: `x_valid = (x_count != 0)` and `x_data = mem_x[rd_ptr_x]`. A pop when `x_valid & x_ready` increments `rd_ptr_x` and decrements the count.
- Push and pop on the same channel in the same cycle leave the count unchanged, and both pointers advance.
- Full channel: a push is refused even if a pop occurs in the same cycle. `in_ready` stays low for that selection that cycle.
- Empty channel: `x_ready` is ignored and nothing changes.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count ranges 0..DEPTH.
- Ordering is preserved within a channel. There is no ordering relation between channels.
- `in_sel` and `in_data` are sampled only on accept. Changing them while `in_valid` is high and `in_ready` is low is legal, and the new selection takes effect immediately.
- No word is dropped or duplicated under any handshake combination.

## Timing
- Reset (asynchronous, while `reset_n` = 0):
  - all pointers and counts go to 0;
  - `a_valid` = `b_valid` = 0;
  - `a_count` = `b_count` = 0;
  - storage is cleared, so `a_data` = `b_data` = 0;
  - `in_ready` = 1 for both selections.
- Reset asserted mid-transfer discards all queued words, and the outputs go to reset values immediately.
- Release is synchronous in effect: the first accept can occur on the first rising edge with `reset_n` = 1.
- Latency: a word accepted at edge N is visible on `x_valid`/`x_data` after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle per input while the destination keeps popping. With DEPTH = 2, a continuously ready consumer never causes `in_ready` to drop.
- `x_count` updates on the same edge as the push/pop that changes it.

## Structure
- Shared package/header: a constant for the pointer width, `$clog2(DEPTH)`, and the channel-select encoding (`SEL_A` = 0, `SEL_B` = 1).
- One sub-module: `demux_fifo`, parameterised by B and DEPTH. Ports: `clk`, `reset_n`, push, `push_data`, `full`, pop, `valid`, `head_data`, `count`.
- The top level instantiates `demux_fifo` twice and contains only the select/ready steering.

## Test plan
- Reset values: assert `reset_n` = 0 mid-run with both channels holding 2 words. Required: immediately `a_valid` = `b_valid` = 0, both counts 0, both data outputs 0, `in_ready` = 1.
- Routing: push 0x11111111 with sel 0, then 0x22222222 with sel 1, both consumers ready. Required: A delivers 0x11111111 in cycle 2, B delivers 0x22222222 in cycle 3, each exactly once.
- Isolation: `b_ready` = 0. Push 0xB0, 0xB1 to B, then 0xA0 to A.
  - After the second B push, `b_count` = 2 and `in_ready` = 0 for sel 1.
  - The A push is accepted immediately.
  - Raising `b_ready` then yields 0xB0, then 0xB1.
- Full with simultaneous pop: channel A full, `a_ready` = 1, `in_valid` = 1, sel 0. Required: `in_ready` = 0 that cycle and `a_count` drops to 1; the push is accepted the next cycle and `a_count` returns to 2.
- Wrap-around: 10 back-to-back words 0..9 to A with `a_ready` toggling every cycle. Required: output order 0..9, no loss, `a_count` never exceeds 2.
- Random soak: 10k cycles of random `in_valid`, `in_sel`, `a_ready`, `b_ready`, checked against a scoreboard model. Required: zero mismatches and no `in_ready` change caused by a same-cycle `x_ready`.
